udp_send: RTL and testbench

Transmit-side UDP framer. Accepts a raw application byte stream with sideband port and length fields, prepends the 8-byte UDP header, and presents a byte-wide AXI-Stream frame to the IP transmit layer. Checksum field is always transmitted as 0x0000, which means "not computed" for UDP over IPv4. Mirror of the UDP receive path: both share the same byte ordering and handshake style.

---
 rtl/udp_send.sv | 223 ++++++++++++++++++++++
 tb/tb_udp_send.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_send.sv
// udp_send: prepends an 8-byte UDP header (checksum 0x0000) to an application byte stream.
// Latency: header byte 0 valid 2 cycles after the first input beat; then 1 byte/cycle, no bubbles.
// Backpressure: single output register freezes while udp_axis_tready_in is low; input ready follows it in DATA.
// Optional feature macro: UDP_TX_LEN_CHECK_EN (force frame length to the declared length via pad/drop).
module udp_send (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  udpdata_tdata_in,
    input  logic        udpdata_tvalid_in,
    input  logic        udpdata_tlast_in,
    output logic        udpdata_tready_out,
    input  logic [15:0] src_port_in,
    input  logic [15:0] dest_port_in,
    input  logic [15:0] payload_len_in,
    output logic [7:0]  udp_axis_tdata_out,
    output logic        udp_axis_tvalid_out,
    output logic        udp_axis_tlast_out,
    input  logic        udp_axis_tready_in,
    output logic        busy_out,
    output logic        len_err_out
);

`ifdef UDP_TX_LEN_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_PAD, S_DROP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;
`endif

    state_t      state;
    state_t      state_nxt;

    // Per-datagram context latched on the first beat.
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic [15:0] len_q;      // UDP length field = payload + 8
    logic [15:0] rem;        // payload bytes still owed to the frame
    logic [2:0]  hdr_idx;

    // Output register.
    logic [7:0]  out_dat;
    logic        out_vld;
    logic        out_last;

    // Control decoded by the FSM.
    logic        advance;
    logic        ld;
    logic [7:0]  ld_dat;
    logic        ld_last;
    logic        cap;
    logic        hdr_inc;
    logic        rem_dec;
    logic        in_rdy;
    logic [7:0]  hdr_byte;

`ifdef UDP_TX_LEN_CHECK_EN
    logic        err;
    logic        len_err;
`endif

    // The output register may take a new byte when empty or when its byte leaves this cycle.
    assign advance = !out_vld || udp_axis_tready_in;

    // Header byte selected by hdr_idx, ports and length MSB first, checksum zero.
    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_idx)
            3'd0:    hdr_byte = src_q[15:8];
            3'd1:    hdr_byte = src_q[7:0];
            3'd2:    hdr_byte = dst_q[15:8];
            3'd3:    hdr_byte = dst_q[7:0];
            3'd4:    hdr_byte = len_q[15:8];
            3'd5:    hdr_byte = len_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // Next-state and datapath control; the triggering beat in IDLE is left pending.
    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        ld_dat    = 8'h00;
        ld_last   = 1'b0;
        cap       = 1'b0;
        hdr_inc   = 1'b0;
        rem_dec   = 1'b0;
        in_rdy    = 1'b0;
`ifdef UDP_TX_LEN_CHECK_EN
        err       = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (udpdata_tvalid_in) begin
                    cap       = 1'b1;
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (advance) begin
                    ld      = 1'b1;
                    ld_dat  = hdr_byte;
                    hdr_inc = 1'b1;
                    if (hdr_idx == 3'd7) begin
`ifdef UDP_TX_LEN_CHECK_EN
                        if (rem == 16'd0) begin
                            // Empty datagram: frame ends on the header, pending input is discarded.
                            ld_last   = 1'b1;
                            err       = !udpdata_tlast_in;
                            state_nxt = S_DROP;
                        end else begin
                            state_nxt = S_DATA;
                        end
`else
                        state_nxt = S_DATA;
`endif
                    end
                end
            end
            S_DATA: begin
                in_rdy = advance;
                if (advance && udpdata_tvalid_in) begin
                    ld      = 1'b1;
                    ld_dat  = udpdata_tdata_in;
                    rem_dec = 1'b1;
`ifdef UDP_TX_LEN_CHECK_EN
                    if (rem == 16'd1) begin
                        ld_last = 1'b1;
                        if (udpdata_tlast_in) begin
                            state_nxt = S_IDLE;
                        end else begin
                            err       = 1'b1;
                            state_nxt = S_DROP;
                        end
                    end else if (udpdata_tlast_in) begin
                        err       = 1'b1;
                        state_nxt = S_PAD;
                    end
`else
                    ld_last = udpdata_tlast_in;
                    if (udpdata_tlast_in) begin
                        state_nxt = S_IDLE;
                    end
`endif
                end
            end
`ifdef UDP_TX_LEN_CHECK_EN
            S_PAD: begin
                if (advance) begin
                    ld      = 1'b1;
                    ld_dat  = 8'h00;
                    rem_dec = 1'b1;
                    if (rem == 16'd1) begin
                        ld_last   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                in_rdy = 1'b1;
                if (udpdata_tvalid_in && udpdata_tlast_in) begin
                    state_nxt = S_IDLE;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, per-datagram context and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            src_q    <= 16'h0000;
            dst_q    <= 16'h0000;
            len_q    <= 16'h0000;
            rem      <= 16'h0000;
            hdr_idx  <= 3'd0;
            out_dat  <= 8'h00;
            out_vld  <= 1'b0;
            out_last <= 1'b0;
`ifdef UDP_TX_LEN_CHECK_EN
            len_err  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
`ifdef UDP_TX_LEN_CHECK_EN
            len_err <= err;
`endif
            if (cap) begin
                src_q   <= src_port_in;
                dst_q   <= dest_port_in;
                len_q   <= payload_len_in + 16'd8;
                rem     <= payload_len_in;
                hdr_idx <= 3'd0;
            end
            if (hdr_inc) begin
                hdr_idx <= hdr_idx + 3'd1;
            end
            if (rem_dec) begin
                rem <= rem - 16'd1;
            end
            if (ld) begin
                out_dat  <= ld_dat;
                out_vld  <= 1'b1;
                out_last <= ld_last;
            end else if (udp_axis_tready_in) begin
                out_vld  <= 1'b0;
                out_last <= 1'b0;
            end
        end
    end

    assign udp_axis_tdata_out  = out_dat;
    assign udp_axis_tvalid_out = out_vld;
    assign udp_axis_tlast_out  = out_last;
    assign udpdata_tready_out  = in_rdy;
    assign busy_out            = (state != S_IDLE) || out_vld;
`ifdef UDP_TX_LEN_CHECK_EN
    assign len_err_out         = len_err;
`else
    assign len_err_out         = 1'b0;
`endif

endmodule

// File: tb/tb_udp_send.sv
// Bench for udp_send: directed vectors, hand-written timing/reset sequences and random datagrams
// checked against a frame-level reference model and an output scoreboard.
module tb_udp_send;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  udpdata_tdata_in;
    logic        udpdata_tvalid_in;
    logic        udpdata_tlast_in;
    logic        udpdata_tready_out;
    logic [15:0] src_port_in;
    logic [15:0] dest_port_in;
    logic [15:0] payload_len_in;
    logic [7:0]  udp_axis_tdata_out;
    logic        udp_axis_tvalid_out;
    logic        udp_axis_tlast_out;
    logic        udp_axis_tready_in;
    logic        busy_out;
    logic        len_err_out;

    always #5 clk = ~clk;

    udp_send dut (
        .clk                (clk),
        .reset              (reset),
        .udpdata_tdata_in   (udpdata_tdata_in),
        .udpdata_tvalid_in  (udpdata_tvalid_in),
        .udpdata_tlast_in   (udpdata_tlast_in),
        .udpdata_tready_out (udpdata_tready_out),
        .src_port_in        (src_port_in),
        .dest_port_in       (dest_port_in),
        .payload_len_in     (payload_len_in),
        .udp_axis_tdata_out (udp_axis_tdata_out),
        .udp_axis_tvalid_out(udp_axis_tvalid_out),
        .udp_axis_tlast_out (udp_axis_tlast_out),
        .udp_axis_tready_in (udp_axis_tready_in),
        .busy_out           (busy_out),
        .len_err_out        (len_err_out)
    );

    typedef logic [7:0] bq_t[$];
    typedef struct packed { logic [7:0] dat; logic last; } obyte_t;
    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        int          plen;
        int          nin;
        int          gaps;
        int          mode;
        int          flen;
        int          err;
    } vec_t;

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     rdy_mode = 0;
    bit     mon_en = 1'b1;
    obyte_t expq[$];
    int     acc_cyc[$];
    logic [7:0] acc_dat[$];
    int     frame_lens[$];
    int     err_pulses = 0;
    vec_t   vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter advanced on each rising edge.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream ready pattern: 0 = always high, 1 = toggling, 2 = random.
    initial begin
        udp_axis_tready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       udp_axis_tready_in = 1'b1;
                1:       udp_axis_tready_in = ~udp_axis_tready_in;
                default: udp_axis_tready_in = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: scoreboard compare, hold stability, frame lengths, error pulses.
    initial begin
        bit         hold_pend;
        logic [7:0] hold_dat;
        logic       hold_last;
        int         frame_cnt;
        obyte_t     e;
        hold_pend = 1'b0;
        frame_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset && mon_en) begin
                if (hold_pend) begin
                    check("hold_vld", 32'(udp_axis_tvalid_out), 1);
                    check("hold_dat", 32'(udp_axis_tdata_out), 32'(hold_dat));
                    check("hold_last", 32'(udp_axis_tlast_out), 32'(hold_last));
                end
                hold_pend = udp_axis_tvalid_out && !udp_axis_tready_in;
                hold_dat  = udp_axis_tdata_out;
                hold_last = udp_axis_tlast_out;
                if (len_err_out) err_pulses++;
                if (udp_axis_tvalid_out && udp_axis_tready_in) begin
                    acc_cyc.push_back(cyc);
                    acc_dat.push_back(udp_axis_tdata_out);
                    if (expq.size() == 0) begin
                        check("extra_byte", 32'(expq.size()), 1);
                    end else begin
                        e = expq.pop_front();
                        check("out_dat", 32'(udp_axis_tdata_out), 32'(e.dat));
                        check("out_last", 32'(udp_axis_tlast_out), 32'(e.last));
                    end
                    frame_cnt++;
                    if (udp_axis_tlast_out) begin
                        frame_lens.push_back(frame_cnt);
                        frame_cnt = 0;
                    end
                end
            end else begin
                hold_pend = 1'b0;
                frame_cnt = 0;
            end
        end
    end

    // Reference model: expected frame for a datagram, from the framing rules.
    function automatic void expect_frame(input logic [15:0] s, input logic [15:0] d,
                                         input logic [15:0] plen, input bq_t p);
        logic [15:0] l;
        logic [7:0]  hdr[8];
        int          nout;
        l = plen + 16'd8;
        hdr = '{s[15:8], s[7:0], d[15:8], d[7:0], l[15:8], l[7:0], 8'h00, 8'h00};
`ifdef UDP_TX_LEN_CHECK_EN
        nout = int'(plen);
`else
        nout = p.size();
`endif
        for (int i = 0; i < 8; i++) expq.push_back('{hdr[i], (i == 7) && (nout == 0)});
        for (int i = 0; i < nout; i++)
            expq.push_back('{(i < p.size()) ? p[i] : 8'h00, i == nout - 1});
    endfunction

    task automatic send(input logic [15:0] s, input logic [15:0] d, input logic [15:0] plen,
                        input bq_t p, input int gaps);
        bit acc;
        int n;
        for (int i = 0; i < p.size(); i++) begin
            if (gaps != 0 && i != 0 && $urandom_range(0, 2) == 0) begin
                udpdata_tvalid_in = 1'b0;
                udpdata_tlast_in  = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            src_port_in       = s;
            dest_port_in      = d;
            payload_len_in    = plen;
            udpdata_tdata_in  = p[i];
            udpdata_tlast_in  = (i == p.size() - 1);
            udpdata_tvalid_in = 1'b1;
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 3000) begin
                @(negedge clk);
                acc = udpdata_tvalid_in && udpdata_tready_out;
                @(posedge clk);
                #1;
                n++;
            end
            check("in_accept", 32'(acc), 1);
            if (!acc) break;
        end
        udpdata_tvalid_in = 1'b0;
        udpdata_tlast_in  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_left", 32'(expq.size()), 0);
        @(negedge clk);
        #1;
        check("busy_idle", 32'(busy_out), 0);
    endtask

    task automatic run_dgram(input logic [15:0] s, input logic [15:0] d, input int plen,
                             input int nin, input int gaps, input int exp_flen,
                             input int exp_err, input string tag);
        bq_t p;
        int  e0;
        int  f0;
        for (int i = 0; i < nin; i++) p.push_back(8'($urandom));
        expect_frame(s, d, plen[15:0], p);
        e0 = err_pulses;
        f0 = frame_lens.size();
        send(s, d, plen[15:0], p, gaps);
        drain();
        check({tag, "_frames"}, 32'(frame_lens.size()), 32'(f0 + 1));
        if (frame_lens.size() > f0) check({tag, "_flen"}, 32'(frame_lens[f0]), 32'(exp_flen));
        check({tag, "_err"}, 32'(err_pulses - e0), 32'(exp_err));
    endtask

    initial begin
        bq_t        p1;
        bq_t        p2;
        logic [7:0] exp_spec[12];
        int         t0;
        int         base;

        reset             = 1'b1;
        udpdata_tdata_in  = 8'h00;
        udpdata_tvalid_in = 1'b0;
        udpdata_tlast_in  = 1'b0;
        src_port_in       = 16'h0000;
        dest_port_in      = 16'h0000;
        payload_len_in    = 16'h0000;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 32'(udp_axis_tvalid_out), 0);
        check("rst_tlast", 32'(udp_axis_tlast_out), 0);
        check("rst_tdata", 32'(udp_axis_tdata_out), 0);
        check("rst_tready", 32'(udpdata_tready_out), 0);
        check("rst_busy", 32'(busy_out), 0);
        check("rst_lenerr", 32'(len_err_out), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reference frame: latency, exact bytes, contiguity, busy.
        exp_spec = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'h00, 8'h00,
                     8'hA0, 8'hA1, 8'hA2, 8'hA3};
        p1 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        rdy_mode = 0;
        acc_cyc.delete();
        acc_dat.delete();
        expect_frame(16'h1234, 16'h0050, 16'd4, p1);
        t0 = cyc;
        fork
            send(16'h1234, 16'h0050, 16'd4, p1, 0);
            begin
                @(negedge clk);
                @(negedge clk);
                check("busy_in_hdr", 32'(busy_out), 1);
            end
        join
        drain();
        check("spec_nbytes", 32'(acc_dat.size()), 12);
        if (acc_dat.size() == 12) begin
            for (int i = 0; i < 12; i++) check("spec_byte", 32'(acc_dat[i]), 32'(exp_spec[i]));
            check("lat_hdr0", 32'(acc_cyc[0] - t0), 2);
            check("lat_pay0", 32'(acc_cyc[8] - t0), 10);
            check("contig", 32'(acc_cyc[11] - acc_cyc[0]), 11);
        end

        // Same frame with toggling downstream ready.
        rdy_mode = 1;
        acc_dat.delete();
        expect_frame(16'h1234, 16'h0050, 16'd4, p1);
        send(16'h1234, 16'h0050, 16'd4, p1, 0);
        drain();
        check("toggle_nbytes", 32'(acc_dat.size()), 12);
        if (acc_dat.size() == 12)
            for (int i = 0; i < 12; i++) check("toggle_byte", 32'(acc_dat[i]), 32'(exp_spec[i]));

        // Back-to-back datagrams.
        rdy_mode = 0;
        @(posedge clk);
        #1;
        acc_cyc.delete();
        acc_dat.delete();
        p1 = '{8'h11};
        p2 = '{8'h21, 8'h22};
        expect_frame(16'hAAAA, 16'h0001, 16'd1, p1);
        expect_frame(16'hBBBB, 16'h0002, 16'd2, p2);
        send(16'hAAAA, 16'h0001, 16'd1, p1, 0);
        send(16'hBBBB, 16'h0002, 16'd2, p2, 0);
        drain();
        check("b2b_nbytes", 32'(acc_cyc.size()), 19);
        if (acc_cyc.size() == 19) begin
            check("b2b_gap", 32'(acc_cyc[9] - acc_cyc[8]), 2);
            check("b2b_hdr0", 32'(acc_dat[9]), 32'h0BB);
        end

        // Directed vectors.
        vt.push_back('{16'hC000, 16'h0044,   1,   1, 0, 2,   9, 0});
        vt.push_back('{16'h8001, 16'hFFFF,   7,   7, 1, 1,  15, 0});
        vt.push_back('{16'h00FF, 16'h0100, 300, 300, 1, 2, 308, 0});
        vt.push_back('{16'hABCD, 16'h1234,   2,   2, 0, 0,  10, 0});
`ifdef UDP_TX_LEN_CHECK_EN
        vt.push_back('{16'h1111, 16'h2222,   4,   2, 0, 0,  12, 1});
        vt.push_back('{16'h3333, 16'h4444,   2,   5, 0, 0,  10, 1});
        vt.push_back('{16'h5555, 16'h6666,   0,   1, 0, 2,   8, 0});
        vt.push_back('{16'h7777, 16'h8888,   0,   3, 1, 1,   8, 1});
        vt.push_back('{16'h9999, 16'hAAAA,   3,   3, 1, 2,  11, 0});
`endif
        for (int v = 0; v < vt.size(); v++) begin
            rdy_mode = vt[v].mode;
            run_dgram(vt[v].src, vt[v].dst, vt[v].plen, vt[v].nin, vt[v].gaps,
                      vt[v].flen, vt[v].err, "vec");
        end

        // Reset mid-payload of a 16-byte frame.
        rdy_mode = 0;
        mon_en   = 1'b0;
        src_port_in       = 16'hDEAD;
        dest_port_in      = 16'hBEEF;
        payload_len_in    = 16'd16;
        udpdata_tdata_in  = 8'h55;
        udpdata_tlast_in  = 1'b0;
        udpdata_tvalid_in = 1'b1;
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_busy", 32'(busy_out), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_tvalid", 32'(udp_axis_tvalid_out), 0);
        check("mid_rst_tlast", 32'(udp_axis_tlast_out), 0);
        check("mid_rst_tdata", 32'(udp_axis_tdata_out), 0);
        check("mid_rst_tready", 32'(udpdata_tready_out), 0);
        check("mid_rst_busy", 32'(busy_out), 0);
        check("mid_rst_lenerr", 32'(len_err_out), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        udpdata_tvalid_in = 1'b0;
        expq.delete();
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc.delete();
        acc_dat.delete();
        base = frame_lens.size();
        t0 = cyc;
        run_dgram(16'h0A0B, 16'h0C0D, 5, 5, 0, 13, 0, "post_rst");
        check("post_rst_frames", 32'(frame_lens.size()), 32'(base + 1));
        if (acc_cyc.size() > 0) begin
            check("post_rst_lat", 32'(acc_cyc[0] - t0), 2);
            check("post_rst_hdr0", 32'(acc_dat[0]), 32'h0A);
        end

        // Random datagrams.
        for (int k = 0; k < 20; k++) begin
            int plen;
            int nin;
            int fl;
            int er;
            rdy_mode = int'($urandom_range(0, 2));
`ifdef UDP_TX_LEN_CHECK_EN
            plen = int'($urandom_range(0, 24));
            nin  = int'($urandom_range(1, plen + 3));
            fl   = 8 + plen;
            er   = (plen == 0) ? int'(nin > 1) : int'(nin != plen);
`else
            plen = int'($urandom_range(1, 24));
            nin  = plen;
            fl   = 8 + nin;
            er   = 0;
`endif
            run_dgram(16'($urandom), 16'($urandom), plen, nin, int'($urandom_range(0, 1)),
                      fl, er, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
